// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with circular return-address stack
module pc_sequencer #(
  parameter int unsigned         XLEN      = 32,
  parameter int unsigned         STEP      = 4,
  parameter logic [XLEN-1:0]     RESET_VEC = '0,
  parameter int unsigned         RAS_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          branch,
  input  logic                          call,
  input  logic                          ret,
  input  logic [XLEN-1:0]               target,
  output logic [XLEN-1:0]               pc_out,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
  output logic                          ras_empty,
  output logic                          ras_full,
  output logic                          ras_overflow,
  output logic                          ret_err
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  // Stack storage; wr_ptr is the next free slot, the top entry sits just below it.
  // When full, wr_ptr also points at the oldest entry, so a push overwrites it.
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] top_entry;

  logic [XLEN-1:0] pc_nxt;
  logic [CW-1:0]   count_nxt;
  logic [PW-1:0]   wr_ptr_nxt;
  logic            overflow_nxt;
  logic            ret_err_nxt;
  logic            mem_we;
  logic [PW-1:0]   mem_waddr;

  assign seq_pc    = pc_out + XLEN'(STEP);
  assign rd_ptr    = wr_ptr - PW'(1);
  assign top_entry = ras_mem[rd_ptr];
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));

  // Resolve the single action for this cycle: stall > ret > call > branch > sequential.
  always_comb begin
    pc_nxt       = seq_pc;
    count_nxt    = ras_count;
    wr_ptr_nxt   = wr_ptr;
    overflow_nxt = ras_overflow;
    ret_err_nxt  = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = wr_ptr;

    if (stall) begin
      pc_nxt = pc_out;
    end else if (ret && call) begin
      if (ras_empty) begin
        // Nothing to pop: behaves as a plain call, but still flags the bad return.
        pc_nxt      = target;
        mem_we      = 1'b1;
        mem_waddr   = wr_ptr;
        wr_ptr_nxt  = wr_ptr + PW'(1);
        count_nxt   = CW'(1);
        ret_err_nxt = 1'b1;
      end else begin
        // Pop and push in one go: the top slot is replaced in place.
        pc_nxt    = top_entry;
        mem_we    = 1'b1;
        mem_waddr = rd_ptr;
      end
    end else if (ret) begin
      if (ras_empty) begin
        ret_err_nxt = 1'b1;
      end else begin
        pc_nxt     = top_entry;
        wr_ptr_nxt = rd_ptr;
        count_nxt  = ras_count - CW'(1);
      end
    end else if (call) begin
      pc_nxt     = target;
      mem_we     = 1'b1;
      mem_waddr  = wr_ptr;
      wr_ptr_nxt = wr_ptr + PW'(1);
      if (ras_full) begin
        overflow_nxt = 1'b1;
      end else begin
        count_nxt = ras_count + CW'(1);
      end
    end else if (branch) begin
      pc_nxt = target;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out       <= RESET_VEC;
      ras_count    <= '0;
      wr_ptr       <= '0;
      ras_overflow <= 1'b0;
      ret_err      <= 1'b0;
    end else begin
      pc_out       <= pc_nxt;
      ras_count    <= count_nxt;
      wr_ptr       <= wr_ptr_nxt;
      ras_overflow <= overflow_nxt;
      ret_err      <= ret_err_nxt;
    end
  end

  // Stack storage write port; contents are not reset since ras_count gates validity.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      ras_mem[mem_waddr] <= seq_pc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard testbench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] pc_out;
  logic [3:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;
  logic        ret_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  cnt;
    logic        ovf;
    logic        rerr;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .call(call), .ret(ret),
    .target(target), .pc_out(pc_out), .ras_count(ras_count), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_overflow(ras_overflow), .ret_err(ret_err)
  );

  always #5 clk = ~clk;

  // Issue one cycle of stimulus and queue the state expected after the next rising edge.
  task automatic step(input logic r, input logic st, input logic br, input logic ca,
                      input logic re, input logic [31:0] tgt, input logic [31:0] epc,
                      input logic [3:0] ecnt, input logic eovf, input logic eerr,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; branch = br; call = ca; ret = re; target = tgt;
    e.pc = epc; e.cnt = ecnt; e.ovf = eovf; e.rerr = eerr; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, field, act, req);
    end
  endtask

  // Monitor: after every rising edge, compare DUT state against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "pc_out", pc_out, e.pc);
      chk(e.name, "ras_count", {28'd0, ras_count}, {28'd0, e.cnt});
      chk(e.name, "ras_empty", {31'd0, ras_empty}, {31'd0, e.cnt == 4'd0});
      chk(e.name, "ras_full", {31'd0, ras_full}, {31'd0, e.cnt == 4'd8});
      chk(e.name, "ras_overflow", {31'd0, ras_overflow}, {31'd0, e.ovf});
      chk(e.name, "ret_err", {31'd0, ret_err}, {31'd0, e.rerr});
    end
  end

  initial begin
    // Reset and idle stepping
    step(1, 0, 0, 0, 0, 32'h0, 32'h0000_0000, 0, 0, 0, "reset");
    step(0, 0, 0, 0, 0, 32'h0, 32'h0000_0004, 0, 0, 0, "idle1");
    step(0, 0, 0, 0, 0, 32'h0, 32'h0000_0008, 0, 0, 0, "idle2");
    step(0, 0, 0, 0, 0, 32'h0, 32'h0000_000C, 0, 0, 0, "idle3");

    // Call / return round trip
    step(0, 0, 1, 0, 0, 32'h100, 32'h0000_0100, 0, 0, 0, "br_100");
    step(0, 0, 0, 1, 0, 32'h400, 32'h0000_0400, 1, 0, 0, "call_400");
    step(0, 0, 0, 0, 0, 32'h0,   32'h0000_0404, 1, 0, 0, "idle_404");
    step(0, 0, 0, 0, 0, 32'h0,   32'h0000_0408, 1, 0, 0, "idle_408");
    step(0, 0, 0, 0, 1, 32'h0,   32'h0000_0104, 0, 0, 0, "ret_104");

    // Simultaneous call+ret with one entry (0x104) at pc 0x200
    step(0, 0, 1, 0, 0, 32'h100, 32'h0000_0100, 0, 0, 0, "br_100b");
    step(0, 0, 0, 1, 0, 32'h400, 32'h0000_0400, 1, 0, 0, "call_400b");
    step(0, 0, 1, 0, 0, 32'h200, 32'h0000_0200, 1, 0, 0, "br_200");
    step(0, 0, 0, 1, 1, 32'h999, 32'h0000_0104, 1, 0, 0, "callret_full");
    step(0, 0, 0, 0, 1, 32'h0,   32'h0000_0204, 0, 0, 0, "ret_204");

    // Simultaneous call+ret on empty stack, then empty ret
    step(0, 0, 0, 1, 1, 32'h300, 32'h0000_0300, 1, 0, 1, "callret_empty");
    step(0, 0, 0, 0, 1, 32'h0,   32'h0000_0208, 0, 0, 0, "ret_208");
    step(0, 0, 0, 0, 0, 32'h0,   32'h0000_020C, 0, 0, 0, "idle_20c");

    // Stall holds everything and suppresses redirects and ret_err
    step(0, 1, 1, 0, 0, 32'h500, 32'h0000_020C, 0, 0, 0, "stall_br");
    step(0, 1, 0, 0, 1, 32'h0,   32'h0000_020C, 0, 0, 0, "stall_ret");
    step(0, 1, 0, 1, 0, 32'h700, 32'h0000_020C, 0, 0, 0, "stall_call");

    // Nine calls into an eight-deep stack (branch asserted on one call is ignored)
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, (i == 3), 1, 0, 32'h1000 * i, 32'h1000 * i,
           (i > 8) ? 4'd8 : 4'(i), (i == 9), 0, $sformatf("call%0d", i));
    end
    // Eight returns newest-first, then a ret on the empty stack
    for (int j = 1; j <= 8; j++) begin
      step(0, 0, (j == 2), 0, 1, 32'hDEAD_0000, 32'h1000 * (9 - j) + 32'h4,
           4'(8 - j), 1, 0, $sformatf("ret%0d", j));
    end
    step(0, 0, 0, 0, 1, 32'h0, 32'h0000_1008, 0, 1, 1, "ret9_empty");
    step(0, 0, 0, 0, 0, 32'h0, 32'h0000_100C, 0, 1, 0, "idle_after_err");

    // Wrap at the top of the address space
    step(0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1, 0, "br_max");
    step(0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 0, 1, 0, "wrap");

    // Mid-operation reset with five entries and a pending ret
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0, 1, 0, 32'h10 * k, 32'h10 * k, 4'(k), 1, 0, $sformatf("fill%0d", k));
    end
    step(1, 1, 1, 1, 1, 32'h1234, 32'h0000_0000, 0, 0, 0, "reset_mid");
    step(0, 0, 0, 0, 0, 32'h0,    32'h0000_0004, 0, 0, 0, "post_reset");
    step(0, 0, 0, 0, 1, 32'h0,    32'h0000_0008, 0, 0, 1, "ret_after_reset");

    @(negedge clk);
    rst = 0; stall = 0; branch = 0; call = 0; ret = 0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC width in bits (>=8).
REQ-002 SHALL have parameter STEP, default 4, sequential increment (power of two, >=1).
REQ-003 SHALL have parameter RESET_VEC, default 0, PC value after reset.
REQ-004 SHALL have parameter RAS_DEPTH, default 8, return-address-stack entries (power of two, >=2).
REQ-005 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have stall  input  1  hold all state this cycle.
REQ-008 SHALL have branch  input  1  redirect PC to target.
REQ-009 SHALL have call  input  1  redirect to target and push return address.
REQ-010 SHALL have ret  input  1  redirect to popped return address.
REQ-011 SHALL have target  input  XLEN  branch/call destination.
REQ-012 SHALL have pc_out  output  XLEN  current PC, registered.
REQ-013 SHALL have ras_count  output  $clog2(RAS_DEPTH)+1  valid stack entries, registered.
REQ-014 SHALL have ras_empty, ras_full  output  1 each  combinational decodes of ras_count (==0, ==RAS_DEPTH).
REQ-015 SHALL have ras_overflow  output  1  sticky flag, set when a call overwrote the oldest entry.
REQ-016 SHALL have ret_err  output  1  one-cycle registered pulse, ret with empty stack.

Function
REQ-017 SHALL evaluate one action per non-stalled cycle, priority: rst > stall > ret > call > branch > sequential.
REQ-018 Sequential: SHALL set pc_out <= pc_out + STEP, modulo 2^XLEN (wrap from max to low bits, no flag).
REQ-019 Branch (branch=1, call=0, ret=0): SHALL set pc_out <= target, stack untouched.
REQ-020 Call (call=1, ret=0): SHALL set pc_out <= target, push pc_out + STEP (mod 2^XLEN); branch ignored.
REQ-021 Call when ras_full: SHALL overwrite oldest entry (circular buffer), ras_count stays RAS_DEPTH, ras_overflow <= 1.
REQ-022 Ret (ret=1, call=0) with ras_count>0: SHALL set pc_out <= top entry, decrement ras_count; branch ignored.
REQ-023 Ret with ras_empty: SHALL behave as sequential step (pc_out + STEP), ras_count stays 0, ret_err pulses next cycle.
REQ-024 Ret and call together with ras_count>0: SHALL set pc_out <= popped top, then replace that top slot with pc_out + STEP; ras_count unchanged.
REQ-025 Ret and call together with ras_empty: SHALL set pc_out <= target, push pc_out + STEP (count becomes 1), pulse ret_err.
REQ-026 Stall: SHALL hold pc_out, stack contents, ras_count, ras_overflow; ret_err SHALL be 0 next cycle.
REQ-027 ret_err SHALL be 0 in every cycle not following a qualifying empty-stack ret.
REQ-028 Stack SHALL be LIFO; after k pushes with no overflow, k pops return addresses in reverse push order.
REQ-029 Stack storage SHALL use read/write pointers modulo RAS_DEPTH; no storage reset required.
REQ-030 A branch/call/ret redirect SHALL take effect on pc_out exactly one clock after the request cycle.

Reset
REQ-031 On rst=1 at clock edge: pc_out <= RESET_VEC, ras_count <= 0, pointers <= 0, ras_overflow <= 0, ret_err <= 0.
REQ-032 rst SHALL override stall, branch, call, ret in the same cycle; mid-operation reset discards all stack entries.
REQ-033 First cycle after rst deasserts with no request: pc_out SHALL become RESET_VEC + STEP.

Verification
REQ-034 Reset then 3 idle cycles (defaults) -> pc_out 0, 4, 8, 12; ras_empty=1.
REQ-035 At pc_out=0x100 call target=0x400, 2 idle cycles, ret -> pc_out 0x400, 0x404, 0x408, then 0x104; ras_count 1 then 0.
REQ-036 9 consecutive calls (RAS_DEPTH=8) then 9 rets -> ras_overflow=1 after 9th call; 8 rets return addresses newest-first, 9th ret: ret_err pulse, pc_out += 4.
REQ-037 pc_out=0xFFFFFFFC idle -> pc_out=0x00000000; stall asserted with branch=1 -> pc_out held, no redirect.
REQ-038 Simultaneous call+ret with 1 entry (0x104) at pc_out=0x200 -> pc_out=0x104, ras_count=1, top=0x204.
REQ-039 rst asserted with ras_count=5 and ret=1 -> pc_out=RESET_VEC, ras_count=0, ras_overflow=0, no ret_err.
